// File: rtl/cpu_sfifo.sv
// cpu_sfifo - parametrised synchronous FIFO for the CPU fetch/LSU <-> bus path.
//
// Capacity is 2^DEPTH entries; the pointers carry one extra wrap bit so a
// completely full FIFO can be told apart from an empty one.
// FWFT=0 gives a registered dout with one cycle of read latency.
// FWFT=1 shows the head word on dout whenever the FIFO is not empty.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   flush        synchronous clear of the contents and the error flags
//   wr_en, din   write request and write data
//   rd_en        read / pop request
//   dout         read data
//   dout_vld     standard mode: dout was updated by a read this cycle
//                FWFT mode: same as ~empty
//   empty, full  occupancy is 0 / 2^DEPTH
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        current occupancy (DEPTH+1 bits)
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module cpu_sfifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CAP = 1 << DEPTH;
    localparam logic [DEPTH:0] AF_L = (DEPTH+1)'(AF_LEVEL);
    localparam logic [DEPTH:0] AE_L = (DEPTH+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [CAP];
    logic [DEPTH:0]   wr_ptr;
    logic [DEPTH:0]   rd_ptr;
    logic [DEPTH-1:0] wr_idx;
    logic [DEPTH-1:0] rd_idx;
    logic             rd_acc;
    logic             wr_acc;

    // All status is derived from the registered pointers only.
    always_comb begin
        wr_idx       = wr_ptr[DEPTH-1:0];
        rd_idx       = rd_ptr[DEPTH-1:0];
        count        = wr_ptr - rd_ptr;
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_idx == rd_idx) && (wr_ptr[DEPTH] != rd_ptr[DEPTH]);
        almost_full  = (count >= AF_L);
        almost_empty = (count <= AE_L);
        rd_acc       = rd_en & ~empty;
        // A write into a full FIFO is allowed when a pop frees a slot this cycle.
        wr_acc       = wr_en & (~full | rd_acc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en & ~wr_acc)
                overflow <= 1'b1;
            if (rd_en & ~rd_acc)
                underflow <= 1'b1;
        end
    end

    // The storage array has no reset. While rst is low the pointers are held
    // at zero, so anything written into the array is never made visible.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush)
            mem[wr_idx] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is driven straight from the array; it is forced to
            // zero while empty so that reset shows dout = 0 at once.
            always_comb begin
                dout     = empty ? '0 : mem[rd_idx];
                dout_vld = ~empty;
            end
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             vld_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else if (flush) begin
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc)
                        dout_q <= mem[rd_idx];
                end
            end

            always_comb begin
                dout     = dout_q;
                dout_vld = vld_q;
            end
        end
    endgenerate

endmodule
